// File: rtl/mem_stall_ctrl.sv
// Data-memory access sequencer: drives the dmem handshake, freezes the pipeline
// while an access is outstanding and merges hazard-unit stalls/flushes.
module mem_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_access_i,
    input  logic             mem_we_i,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic             hz_stall_f_i,
    input  logic             hz_stall_d_i,
    input  logic             hz_flush_d_i,
    input  logic             hz_flush_e_i,
    input  logic             pc_src_e_i,
    output logic             dmem_req_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_w_o,
    output logic             redirect_en_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_cnt;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_idle;
    logic w_done_nat;
    logic w_timeout;
    logic w_done;
    logic w_mem_stall;

    always_comb begin
        w_done_nat = 1'b0;
        unique case (r_state)
            IDLE:     w_done_nat = mem_access_i & dmem_gnt_i
                                   & (mem_we_i | dmem_rvalid_i);
            WAIT_GNT: w_done_nat = dmem_gnt_i & (mem_we_i | dmem_rvalid_i);
            WAIT_RSP: w_done_nat = dmem_rvalid_i;
            default:  w_done_nat = 1'b0;
        endcase
    end

    assign w_idle      = (r_state == IDLE);
    // A wait that reaches the limit completes anyway, flagged as a bus error.
    assign w_timeout   = !w_idle && (r_cnt == LIM) && !w_done_nat;
    assign w_done      = w_done_nat | w_timeout;
    assign w_mem_stall = !rst_i && (!w_idle || mem_access_i) && !w_done;

    assign dmem_req_o    = !rst_i
                           && ((w_idle && mem_access_i) || r_state == WAIT_GNT);
    assign stall_f_o     = hz_stall_f_i | w_mem_stall;
    assign stall_d_o     = hz_stall_d_i | w_mem_stall;
    assign stall_e_o     = w_mem_stall;
    assign stall_m_o     = w_mem_stall;
    assign flush_w_o     = w_mem_stall;
    assign flush_d_o     = hz_flush_d_i & !w_mem_stall;
    assign flush_e_o     = hz_flush_e_i & !w_mem_stall;
    assign redirect_en_o = pc_src_e_i & !w_mem_stall;
    assign bus_err_o     = r_bus_err;
    assign stall_cnt_o   = r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bus_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_mem_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (mem_access_i && !w_done)
                        r_state <= dmem_gnt_i ? WAIT_RSP : WAIT_GNT;
                end
                WAIT_GNT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (dmem_gnt_i)
                            r_state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (w_done)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: table of single-cycle merge vectors
// plus hand-written multi-cycle access sequences.
module tb_mem_stall_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          mem_access_i, mem_we_i, dmem_gnt_i, dmem_rvalid_i;
    logic          hz_stall_f_i, hz_stall_d_i, hz_flush_d_i, hz_flush_e_i;
    logic          pc_src_e_i;
    logic          dmem_req_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o;
    logic          flush_d_o, flush_e_o, flush_w_o, redirect_en_o, bus_err_o;
    logic [CW-1:0] stall_cnt_o;
    logic [8:0]    w_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_access_i(mem_access_i), .mem_we_i(mem_we_i),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .hz_stall_f_i(hz_stall_f_i), .hz_stall_d_i(hz_stall_d_i),
        .hz_flush_d_i(hz_flush_d_i), .hz_flush_e_i(hz_flush_e_i),
        .pc_src_e_i(pc_src_e_i), .dmem_req_o(dmem_req_o),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o),
        .stall_e_o(stall_e_o), .stall_m_o(stall_m_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .flush_w_o(flush_w_o), .redirect_en_o(redirect_en_o),
        .bus_err_o(bus_err_o), .stall_cnt_o(stall_cnt_o)
    );

    // {req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, redirect}
    assign w_out = {dmem_req_o, stall_f_o, stall_d_o, stall_e_o, stall_m_o,
                    flush_d_o, flush_e_o, flush_w_o, redirect_en_o};

    typedef struct {
        string      name;
        logic       rst;
        logic [8:0] in;   // {acc, we, gnt, rvalid, hz_sf, hz_sd, hz_fd, hz_fe, pc_src}
        logic [8:0] exp;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [8:0] v);
        {mem_access_i, mem_we_i, dmem_gnt_i, dmem_rvalid_i, hz_stall_f_i,
         hz_stall_d_i, hz_flush_d_i, hz_flush_e_i, pc_src_e_i} = v;
    endtask

    task automatic cyc(input logic [8:0] v);
        @(negedge clk);
        apply(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        apply(9'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        vt[0]  = '{"idle_quiet",    1'b0, 9'b000000000, 9'b000000000};
        vt[1]  = '{"hz_loaduse",    1'b0, 9'b000011010, 9'b011000100};
        vt[2]  = '{"hz_branch",     1'b0, 9'b000000111, 9'b000001101};
        vt[3]  = '{"store_gnt",     1'b0, 9'b111000000, 9'b100000000};
        vt[4]  = '{"load_hit_br",   1'b0, 9'b101100011, 9'b100000101};
        vt[5]  = '{"load_gnt_norv", 1'b0, 9'b101000111, 9'b111110010};
        vt[6]  = '{"load_nognt",    1'b0, 9'b100000000, 9'b111110010};
        vt[7]  = '{"store_ngnt_lu", 1'b0, 9'b110011010, 9'b111110010};
        vt[8]  = '{"load_rv_ngnt",  1'b0, 9'b100100000, 9'b111110010};
        vt[9]  = '{"rst_pass",      1'b1, 9'b100000111, 9'b000001101};
        vt[10] = '{"rst_lu",        1'b1, 9'b111011000, 9'b011000000};

        rst_i = 1'b1;
        apply(9'b0);
        #2;
        chk("rst_outputs", {23'b0, w_out}, 32'h0);
        chk("rst_cnt", {28'b0, stall_cnt_o}, 32'h0);
        chk("rst_buserr", {31'b0, bus_err_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_i = vt[i].rst;
            apply(vt[i].in);
            #1;
            chk(vt[i].name, {23'b0, w_out}, {23'b0, vt[i].exp});
            do_reset();
        end

        // Store granted immediately
        cyc(9'b111000000);
        chk("t1_req", {31'b0, dmem_req_o}, 32'd1);
        chk("t1_stall", {31'b0, stall_f_o}, 32'd0);
        cyc(9'b0);
        chk("t1_req_drop", {31'b0, dmem_req_o}, 32'd0);
        chk("t1_cnt", {28'b0, stall_cnt_o}, 32'd0);

        // Load, gnt at cycle 0, rvalid at cycle 3
        do_reset();
        cyc(9'b101000000);
        chk("t2_c0", {23'b0, w_out}, {23'b0, 9'b111110010});
        for (int c = 1; c < 3; c++) begin
            cyc(9'b100000000);
            chk("t2_wait", {23'b0, w_out}, {23'b0, 9'b011110010});
        end
        cyc(9'b100100000);
        chk("t2_release", {23'b0, w_out}, 32'h0);
        cyc(9'b0);
        chk("t2_cnt", {28'b0, stall_cnt_o}, 32'd3);

        // Grant withheld two cycles, then gnt with rvalid
        do_reset();
        for (int c = 0; c < 2; c++) begin
            cyc(9'b100000000);
            chk("t3_wait", {23'b0, w_out}, {23'b0, 9'b111110010});
        end
        cyc(9'b101100000);
        chk("t3_done", {23'b0, w_out}, {23'b0, 9'b100000000});
        cyc(9'b0);
        chk("t3_idle", {23'b0, w_out}, 32'h0);
        chk("t3_cnt", {28'b0, stall_cnt_o}, 32'd2);

        // Frozen branch redirects only on the release cycle
        do_reset();
        cyc(9'b100000111);
        chk("t4_frozen", {29'b0, flush_d_o, flush_e_o, redirect_en_o}, 32'd0);
        cyc(9'b101100111);
        chk("t4_release", {29'b0, flush_d_o, flush_e_o, redirect_en_o}, 32'd7);

        // Timeout in WAIT_RSP, then saturate the counter
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(9'b101000000);
            chk("t5_c0_stall", {31'b0, stall_m_o}, 32'd1);
            for (int c = 1; c < 4; c++) begin
                cyc(9'b100000000);
                chk("t5_wait", {30'b0, stall_m_o, bus_err_o}, 32'd2);
            end
            cyc(9'b100000000);
            chk("t5_forced", {30'b0, stall_m_o, bus_err_o}, 32'd0);
            cyc(9'b0);
            chk("t5_buserr", {23'b0, w_out}, 32'h0);
            chk("t5_buserr_hi", {31'b0, bus_err_o}, 32'd1);
            if (k == 0)
                chk("t5_cnt", {28'b0, stall_cnt_o}, 32'd4);
            cyc(9'b0);
            chk("t5_buserr_lo", {31'b0, bus_err_o}, 32'd0);
        end
        chk("sat_cnt", {28'b0, stall_cnt_o}, 32'd15);

        // Reset while in WAIT_RSP; the late response is ignored
        do_reset();
        cyc(9'b101000000);
        cyc(9'b100000000);
        chk("t6_pre", {31'b0, stall_m_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_out", {23'b0, w_out}, 32'h0);
        chk("t6_rst_cnt", {28'b0, stall_cnt_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc(9'b000100000);
        chk("t6_late_rv", {23'b0, w_out}, 32'h0);
        cyc(9'b0);
        chk("t6_cnt", {29'b0, stall_cnt_o[2:0]}, 32'd0);
        chk("t6_buserr", {31'b0, bus_err_o}, 32'd0);
        cyc(9'b110000000);
        chk("t6_idle_again", {23'b0, w_out}, {23'b0, 9'b111110010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
